serial_add_sub_unit: RTL and testbench

SERIAL_ADD_SUB_UNIT -- requirements
Module: serial_add_sub_unit

---
 rtl/add_sub_pkg.sv | 17 +
 rtl/full_adder_1b.sv | 14 +
 rtl/serial_add_sub_unit.sv | 103 ++++++++++
 tb/tb_serial_add_sub_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/add_sub_pkg.sv
// Shared definitions for the bit-serial add/subtract unit.
package add_sub_pkg;

    localparam int WIDTH = 4;
    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : add_sub_pkg

// File: rtl/full_adder_1b.sv
// Single-bit full adder: the one arithmetic slice shared by every bit position.
module full_adder_1b (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // NOTE: continuous assigns cannot hold state, so no latch can form here.
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule : full_adder_1b

// File: rtl/serial_add_sub_unit.sv
// Bit-serial 4-bit add/subtract unit: accepts a request in IDLE, resolves one
// bit per cycle in CALC (LSB first), and holds the result in DONE until taken.
// Subtraction is done as a + ~b + 1, so cf=1 means "no borrow".
module serial_add_sub_unit
    import add_sub_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             cf,
    output logic             busy
);

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [IDX_W-1:0] idx;
    logic             sum_bit;
    logic             carry_next;
    logic             sub_req;

    // Any opcode other than ADD selects subtraction.
    assign sub_req = (op != OP_ADD);

    full_adder_1b u_fa (
        .a    (op_a[idx]),
        .b    (op_b[idx]),
        .cin  (carry),
        .s    (sum_bit),
        .cout (carry_next)
    );

    // Control FSM and datapath; handshake/status outputs are registered with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            y         <= '0;
            cf        <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every register here sample
            // pre-edge values, so the adder sees this cycle's idx and carry.
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a     <= a;
                        op_b     <= b ^ {WIDTH{sub_req}};
                        carry    <= sub_req;
                        idx      <= '0;
                        state    <= CALC;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end

                CALC: begin
                    y[idx] <= sum_bit;
                    carry  <= carry_next;
                    // Natural 2-bit wrap returns idx to 0 after the last bit.
                    idx    <= idx + IDX_W'(1);
                    if (idx == LAST_IDX) begin
                        cf        <= carry_next;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end

                DONE: begin
                    // Result handshake returns to IDLE; acceptance can only
                    // happen on a later edge because in_valid is ignored here.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule : serial_add_sub_unit

// File: tb/tb_serial_add_sub_unit.sv
// Directed bench for serial_add_sub_unit.
module tb_serial_add_sub_unit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] y;
    logic       cf;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    serial_add_sub_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .cf        (cf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request with out_ready=1; operands are scrambled during CALC
    // while in_valid stays high, so the result must come from the captured values.
    task automatic do_req(input string tag, input logic [3:0] ta, input logic [3:0] tb_v,
                          input logic [1:0] top, input logic [3:0] ey, input logic ecf);
        int n;
        @(negedge clk);
        chk({tag, "_in_ready"}, 8'(in_ready), 8'd1);
        a = ta; b = tb_v; op = top; in_valid = 1'b1;
        @(posedge clk); #1;
        a = ~ta; b = ~tb_v; op = ~top;
        chk({tag, "_busy"}, 8'(busy), 8'd1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
            a = a + 4'd3; b = b + 4'd5;
        end
        in_valid = 1'b0;
        chk({tag, "_latency"}, 8'(n), 8'd4);
        chk({tag, "_y"}, 8'(y), 8'(ey));
        chk({tag, "_cf"}, 8'(cf), 8'(ecf));
        @(posedge clk); #1;
        chk({tag, "_released"}, 8'(out_valid), 8'd0);
    endtask

    initial begin
        int n;
        int last_acc;
        int acc;
        logic [4:0] full;
        logic [3:0] hold_y;
        logic       hold_cf;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b1;
        #12;
        chk("rst_y", 8'(y), 8'd0);
        chk("rst_cf", 8'(cf), 8'd0);
        chk("rst_out_valid", 8'(out_valid), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_in_ready", 8'(in_ready), 8'd1);
        @(negedge clk); rst_n = 1'b1;

        // Additions
        do_req("add_3_2",  4'd3,  4'd2, 2'b00, 4'd5,  1'b0);
        do_req("add_15_1", 4'd15, 4'd1, 2'b00, 4'd0,  1'b1);
        do_req("add_7_7",  4'd7,  4'd7, 2'b00, 4'd14, 1'b0);

        // Reset in the 2nd CALC cycle, with y=14 left from the last result
        @(negedge clk);
        a = 4'd9; b = 4'd4; op = 2'b00; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_y", 8'(y), 8'd0);
        chk("arst_cf", 8'(cf), 8'd0);
        chk("arst_out_valid", 8'(out_valid), 8'd0);
        chk("arst_busy", 8'(busy), 8'd0);
        chk("arst_in_ready", 8'(in_ready), 8'd1);
        @(negedge clk); rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            chk("arst_no_result", 8'(out_valid), 8'd0);
        end

        // Subtractions
        do_req("sub_8_3", 4'd8, 4'd3, 2'b01, 4'd5,  1'b1);
        do_req("sub_5_5", 4'd5, 4'd5, 2'b01, 4'd0,  1'b1);
        do_req("sub_3_5", 4'd3, 4'd5, 2'b01, 4'd14, 1'b0);
        do_req("sub_op3", 4'd8, 4'd3, 2'b11, 4'd5,  1'b1);
        do_req("sub_op2", 4'd2, 4'd9, 2'b10, 4'd9,  1'b0);

        // Backpressure: hold result for 10 cycles with a competing request
        out_ready = 1'b0;
        @(negedge clk);
        a = 4'd12; b = 4'd6; op = 2'b00; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 4'd1; b = 4'd1;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_latency", 8'(n), 8'd4);
        hold_y = 4'd2; hold_cf = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            chk("bp_out_valid", 8'(out_valid), 8'd1);
            chk("bp_y", 8'(y), 8'(hold_y));
            chk("bp_cf", 8'(cf), 8'(hold_cf));
            chk("bp_in_ready", 8'(in_ready), 8'd0);
        end
        in_valid = 1'b0;
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", 8'(out_valid), 8'd0);
        chk("bp_release_in_ready", 8'(in_ready), 8'd1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp_single", 8'(out_valid), 8'd0);
        end

        // Back-to-back exhaustive sweep: every a/b pair for ADD and SUB
        last_acc = -1;
        in_valid = 1'b1;
        for (int k = 0; k < 512; k++) begin
            logic [3:0] va, vb;
            logic       vs;
            va = 4'(k);
            vb = 4'(k >> 4);
            vs = k[8];
            n = 0;
            @(negedge clk);
            while (!in_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (n >= 20) chk("sweep_ready_timeout", 8'(in_ready), 8'd1);
            a = va; b = vb; op = vs ? 2'b01 : 2'b00;
            @(posedge clk);
            acc = cyc;
            #1;
            if (last_acc >= 0) chk("sweep_spacing", 8'(acc - last_acc), 8'd6);
            last_acc = acc;
            a = ~va; b = ~vb; op = ~op;
            n = 0;
            while (!out_valid && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            full = vs ? ({1'b0, va} + {1'b0, ~vb} + 5'd1) : ({1'b0, va} + {1'b0, vb});
            chk("sweep_y", 8'(y), 8'(full[3:0]));
            chk("sweep_cf", 8'(cf), 8'(full[4]));
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_add_sub_unit
